// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    StOff,
    StGap,
    StShow
  } seg_state_e;

  localparam int unsigned BcdW = 4;

  // Code held on the decoder input before any digit has been shown.
  localparam logic [BcdW-1:0] BlankCode = '0;

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppression mask: bit i set means digit i must stay dark.
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic [BcdW*DIGITS-1:0] digits,
  input  logic [DIGITS-1:0]      dps,
  input  logic                   lz_sup,
  output logic [DIGITS-1:0]      mask
);

  logic run;

  // Walk down from the MSD; the first non-zero digit or set dp ends the run.
  always_comb begin
    mask = '0;
    run  = lz_sup;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      run     = run & (digits[i*BcdW +: BcdW] == '0) & ~dps[i];
      mask[i] = run;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans DIGITS BCD digits onto a shared decoder with blank gaps, zero blanking and
// a double-buffered frame that only updates at frame boundaries or while dark.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [BcdW*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]      dp_in,
  input  logic                   lz_sup,
  output logic [BcdW-1:0]        digit_code,
  output logic [DIGITS-1:0]      an,
  output logic                   dp,
  output logic                   upd_ack
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DIGITS - 1);
  localparam logic [CntW-1:0] GapEnd   = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] SlotEnd  = CntW'(REFRESH_DIV - 1);

  seg_state_e             state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BcdW*DIGITS-1:0] shadow_q, active_q;
  logic [DIGITS-1:0]      shadow_dp_q, active_dp_q;
  logic                   pending_q;
  logic [DIGITS-1:0]      mask;
  logic                   boundary, xfer;

  logic [BcdW-1:0]   code_q, code_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              dp_q, dp_d, ack_q;

  seg_lz_mask #(
    .DIGITS (DIGITS)
  ) u_lz_mask (
    .digits (active_q),
    .dps    (active_dp_q),
    .lz_sup (lz_sup),
    .mask   (mask)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = StOff;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StGap;
          idx_d   = '0;
          cnt_d   = '0;
        end
        StGap: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == GapEnd) state_d = StShow;
        end
        StShow: begin
          if (cnt_q == SlotEnd) begin
            state_d = StGap;
            cnt_d   = '0;
            idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  assign boundary = (state_q == StShow) && (idx_q == LastIdx) && (cnt_q == SlotEnd);
  assign xfer     = pending_q && (boundary || (state_q == StOff));

  always_comb begin
    code_d = code_q;
    an_d   = '0;
    dp_d   = 1'b0;
    if (state_q == StShow) begin
      code_d = active_q[idx_q*BcdW +: BcdW];
      if (!mask[idx_q]) begin
        an_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
        dp_d = active_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StOff;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
      pending_q   <= 1'b0;
      code_q      <= BlankCode;
      an_q        <= '0;
      dp_q        <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      ack_q   <= xfer;
      // A load coinciding with a transfer stays pending; the copy uses the old shadow.
      if (load) begin
        shadow_q    <= data_in;
        shadow_dp_q <= dp_in;
      end
      if (xfer) begin
        active_q    <= shadow_q;
        active_dp_q <= shadow_dp_q;
      end
      if (load) pending_q <= 1'b1;
      else if (xfer) pending_q <= 1'b0;
    end
  end

  assign digit_code = code_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign upd_ack    = ack_q;

endmodule
